// File: rtl/tlul_pkg.sv
// TL-UL type definitions shared by hosts and devices on the rvlab bus.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic       a_valid;
    tl_a_op_e   a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic [0:0] d_sink;
    logic [31:0] d_data;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/rvlab_tlul_host.sv
// Single-outstanding TL-UL host adapter: turns a simple req/we/addr initiator
// interface into TL-UL A/D transactions with a response timeout.
module rvlab_tlul_host
  import tlul_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    AREQ,
    DWAIT
  } state_e;

  state_e         state_q;
  logic           we_q;
  logic [29:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     be_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic           gnt_q;
  logic           rvalid_q;
  logic           err_q;
  logic [31:0]    rdata_q;

  tl_d_op_e       exp_d_op;
  logic           resp_err;
  logic [31:0]    resp_data;

  // Response checking uses the latched direction, so it is valid in AREQ and DWAIT.
  assign exp_d_op  = we_q ? AccessAck : AccessAckData;
  assign resp_err  = tl_i.d_error | (tl_i.d_opcode != exp_d_op);
  assign resp_data = we_q ? 32'h0 : tl_i.d_data;
  assign cnt_inc   = cnt_q + CntW'(1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i[31:2];
            wdata_q <= wdata_i;
            be_q    <= be_i;
            state_q <= AREQ;
          end
        end
        AREQ: begin
          if (tl_i.a_ready) begin
            gnt_q <= 1'b1;
            cnt_q <= '0;
            // A D beat coinciding with the handshake belongs to this transaction.
            if (tl_i.d_valid) begin
              rvalid_q <= 1'b1;
              err_q    <= resp_err;
              rdata_q  <= resp_data;
              state_q  <= IDLE;
            end else begin
              state_q  <= DWAIT;
            end
          end
        end
        DWAIT: begin
          if (tl_i.d_valid) begin
            rvalid_q <= 1'b1;
            err_q    <= resp_err;
            rdata_q  <= resp_data;
            state_q  <= IDLE;
          end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            cnt_q    <= cnt_inc;
            state_q  <= IDLE;
          end else begin
            cnt_q    <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the whole struct gets a default first so no field can infer a latch.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == AREQ);
    tl_o.a_opcode  = !we_q ? Get : ((be_q == 4'hF) ? PutFullData : PutPartialData);
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'h0;
    tl_o.a_address = {addr_q, 2'b00};
    tl_o.a_mask    = we_q ? be_q : 4'hF;
    tl_o.a_data    = we_q ? wdata_q : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != IDLE);

  logic unused_inputs;
  assign unused_inputs = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size,
                           tl_i.d_source, tl_i.d_sink};

endmodule

// File: doc/rvlab_tlul_host.md
RVLAB_TLUL_HOST -- requirements
Module: rvlab_tlul_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of DWAIT cycles without a D response before an error completion.
REQ-002 SHALL have port clk_i  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  input  1  request strobe from the local initiator.
REQ-005 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have port addr_i  input  32  byte address.
REQ-007 SHALL have port wdata_i  input  32  write data.
REQ-008 SHALL have port be_i  input  4  byte enables for writes.
REQ-009 SHALL have port gnt_o  output  1  one-cycle pulse when the A-channel handshake completes.
REQ-010 SHALL have port rvalid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata_o  output  32  read data, valid with rvalid_o.
REQ-012 SHALL have port err_o  output  1  error flag, valid with rvalid_o.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request / D-ready.
REQ-015 SHALL have port tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device response / A-ready.

Function
REQ-016 SHALL implement states IDLE, AREQ and DWAIT; only one transaction SHALL be outstanding at any time.
REQ-017 IDLE: req_i=1 SHALL latch we_i, addr_i, wdata_i and be_i, then move to AREQ on the next cycle; req_i SHALL be ignored outside IDLE.
REQ-018 AREQ: tl_o.a_valid SHALL be 1, driven from registers, with all A fields held stable until tl_i.a_ready=1.
REQ-019 AREQ: the cycle with a_valid & a_ready SHALL pulse gnt_o and move to DWAIT.
REQ-020 Opcode selection: read -> Get (4); write with be=4'hF -> PutFullData (0); any other write -> PutPartialData (1).
REQ-021 a_size SHALL be 2; a_address SHALL be {addr[31:2],2'b00}; a_param and a_source SHALL be 0; a_user SHALL be the tlul_pkg default.
REQ-022 a_mask SHALL be 4'hF for Get and be for Put; a_data SHALL be wdata for writes and 0 for reads.
REQ-023 tl_o.d_ready SHALL be constantly 1.
REQ-024 d_valid outside DWAIT SHALL be discarded with no output effect, except when it coincides with the AREQ handshake.
REQ-025 A D response in the same cycle as the AREQ handshake SHALL be treated as that transaction's response: gnt_o and rvalid_o pulse in the same cycle, and the state returns to IDLE.
REQ-026 DWAIT: d_valid=1 SHALL pulse rvalid_o for one cycle and return to IDLE.
REQ-027 On completion, rdata_o SHALL be d_data for reads and 0 for writes.
REQ-028 On completion, err_o SHALL equal d_error OR opcode mismatch (read expects AccessAckData=1, write expects AccessAck=0).
REQ-029 rdata_o and err_o SHALL be registered and SHALL hold their value until the next completion.
REQ-030 DWAIT SHALL run a counter of width $clog2(TIMEOUT_CYCLES+1), cleared on entry to DWAIT.
REQ-031 When the counter reaches TIMEOUT_CYCLES with no d_valid, the block SHALL pulse rvalid_o with err_o=1 and rdata_o=0, then return to IDLE.
REQ-032 A late response arriving after a timeout SHALL be dropped per REQ-024.
REQ-033 Latency: a request accepted in cycle N SHALL assert a_valid in cycle N+1; rvalid_o SHALL pulse in the cycle d_valid is sampled in DWAIT.
REQ-034 busy_o SHALL be 0 only in IDLE; a new request SHALL be accepted in the cycle after rvalid_o.

Reset
REQ-035 Asserting rst_ni low SHALL immediately force IDLE.
REQ-036 Reset SHALL immediately drive tl_o.a_valid=0, gnt_o=0, rvalid_o=0, err_o=0, busy_o=0 and rdata_o=0.
REQ-037 Reset SHALL immediately clear the timeout counter and all latched request fields.
REQ-038 Reset during AREQ or DWAIT SHALL abandon the transaction with no completion pulse.

Verification
REQ-039 Read 0x1000_0004 from a responder with 0 wait states returning 0xCAFE_F00D -> Get, mask F, gnt then rvalid, rdata=0xCAFE_F00D, err=0.
REQ-040 Write 0x1234_5678 with be=4'h3 while a_ready is held low 5 cycles -> PutPartialData, A fields stable for all 5 cycles, mask 3, rvalid, err=0, rdata=0.
REQ-041 Read to which the responder returns d_error=1 -> rvalid with err=1.
REQ-042 Write with be=F answered with AccessAckData -> err=1 (opcode mismatch).
REQ-043 TIMEOUT_CYCLES=8 with the responder silent -> rvalid with err=1 exactly 8 cycles after entering DWAIT; a late d_valid is ignored and a following read completes normally.
REQ-044 rst_ni pulsed low during DWAIT -> a_valid=0, busy=0, no rvalid; the next request completes normally.
